// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions: scoreboard entry layout, operand-select encoding
// and memory access-type bit positions.
package hazard_unit_pkg;
  // Scoreboard dst field is sized for the widest supported register address.
  localparam int SB_REGW_MAX = 8;

  typedef struct packed {
    logic                   valid;
    logic [SB_REGW_MAX-1:0] dst;
    logic                   is_load;
  } sb_entry_t;

  localparam int FWD_RF      = 0;  // operand from register file
  localparam int FWD_SB_BASE = 1;  // sel = d + FWD_SB_BASE picks scoreboard entry d

  localparam int MEM_RD_BIT = 1;
  localparam int MEM_WR_BIT = 0;
endpackage

// File: rtl/hazard_match.sv
// Per-operand priority match of one source register against all scoreboard
// entries; the youngest (lowest-index) matching entry wins.
module hazard_match
  import hazard_unit_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int REGW  = 5,
  parameter int SELW  = $clog2(DEPTH + 1)
) (
  input  sb_entry_t [DEPTH-1:0] sb,
  input  logic [REGW-1:0]       src,
  input  logic                  used,
  output logic                  hit,
  output logic                  is_load_hit,
  output logic [SELW-1:0]       sel
);

  logic [DEPTH-1:0] m;

  always_comb begin
    m = '0;
    for (int d = 0; d < DEPTH; d++)
      m[d] = sb[d].valid && used && (src != '0) && (sb[d].dst == SB_REGW_MAX'(src));
  end

  // Scan oldest to youngest so the last assignment is the youngest match.
  always_comb begin
    hit         = 1'b0;
    is_load_hit = 1'b0;
    sel         = SELW'(FWD_RF);
    for (int d = DEPTH - 1; d >= 0; d--) begin
      if (m[d]) begin
        hit         = 1'b1;
        is_load_hit = sb[d].is_load;
        sel         = SELW'(d + FWD_SB_BASE);
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: memory stalls, branch flush, data-hazard stall and
// operand forwarding selection from a shifting destination scoreboard.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int NSRC   = 2,
  parameter int REGW   = 5,  // must not exceed SB_REGW_MAX
  parameter int DEPTH  = 3,
  parameter int FWD_EN = 1,
  parameter int CNTW   = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                id_valid,
  input  logic [NSRC*REGW-1:0]                id_src,
  input  logic [NSRC-1:0]                     id_src_used,
  input  logic [REGW-1:0]                     id_dst,
  input  logic                                id_regwrite,
  input  logic                                id_is_load,
  input  logic                                branch_taken,
  input  logic                                iready_n,
  input  logic                                dready_n,
  input  logic                                dbusy,
  input  logic [1:0]                          mem_rw,
  output logic                                stall_if,
  output logic                                stall_id,
  output logic                                stall_ex,
  output logic                                stall_mem,
  output logic                                stall_wb,
  output logic                                nop_if,
  output logic                                nop_id,
  output logic                                nop_ex,
  output logic                                nop_mem,
  output logic                                nop_wb,
  output logic [NSRC*$clog2(DEPTH+1)-1:0]     fwd_sel,
  output logic [CNTW-1:0]                     stall_cnt
);

  localparam int SELW = $clog2(DEPTH + 1);

  sb_entry_t [DEPTH-1:0]       sb;
  sb_entry_t                   sb_in;
  logic [NSRC-1:0]             hit, ld_hit, load_use;
  logic [NSRC-1:0][SELW-1:0]   sel;
  logic                        mem_stall, data_haz, haz_stall, bubble;

  for (genvar k = 0; k < NSRC; k++) begin : g_match
    hazard_match #(.DEPTH(DEPTH), .REGW(REGW), .SELW(SELW)) u_match (
      .sb          (sb),
      .src         (id_src[k*REGW +: REGW]),
      .used        (id_src_used[k]),
      .hit         (hit[k]),
      .is_load_hit (ld_hit[k]),
      .sel         (sel[k])
    );
    // Load-use only when the youngest match is the load sitting in EX.
    assign load_use[k] = ld_hit[k] && (sel[k] == SELW'(FWD_SB_BASE));
  end

  assign mem_stall = iready_n | (dready_n & mem_rw[MEM_RD_BIT]) | (dbusy & mem_rw[MEM_WR_BIT]);
  assign data_haz  = id_valid && ((FWD_EN != 0) ? |load_use : |hit);
  assign haz_stall = !mem_stall && !branch_taken && data_haz;
  assign bubble    = branch_taken || haz_stall;
  assign fwd_sel   = (FWD_EN != 0) ? sel : '0;

  always_comb begin
    sb_in = '{valid:   id_valid && id_regwrite && (id_dst != '0),
              dst:     SB_REGW_MAX'(id_dst),
              is_load: id_is_load};
    if (bubble) sb_in = '0;
  end

  always_comb begin
    {stall_if, stall_id, stall_ex, stall_mem, stall_wb} = '0;
    {nop_if, nop_id, nop_ex, nop_mem, nop_wb}           = '0;
    if (mem_stall) begin
      {stall_if, stall_id, stall_ex, stall_mem, stall_wb} = '1;
      nop_if = 1'b1;
    end else if (branch_taken) begin
      {nop_if, nop_id, nop_ex} = '1;
    end else if (data_haz) begin
      stall_id = 1'b1;
      nop_if   = 1'b1;
      nop_ex   = 1'b1;
    end
  end

  // A memory stall freezes the whole scoreboard, so pending hazards keep their age.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb        <= '0;
      stall_cnt <= '0;
    end else if (!mem_stall) begin
      for (int d = DEPTH - 1; d > 0; d--) sb[d] <= sb[d-1];
      sb[0] <= sb_in;
      if (haz_stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench: FWD_EN=0 and FWD_EN=1 instances share stimulus and are
// compared against a behavioural model, a priority table and directed sequences.
module tb_hazard_unit;
  localparam int NSRC = 2, REGW = 5, DEPTH = 3, SELW = 2;

  logic clk = 1'b0, rst = 1'b0;
  logic id_valid, id_regwrite, id_is_load, branch_taken, iready_n, dready_n, dbusy;
  logic [NSRC*REGW-1:0] id_src;
  logic [NSRC-1:0]      id_src_used;
  logic [REGW-1:0]      id_dst;
  logic [1:0]           mem_rw;
  logic [1:0][4:0]      st, np;       // {if,id,ex,mem,wb}
  logic [1:0][NSRC*SELW-1:0] fs;
  logic [15:0] cnt0;
  logic [2:0]  cnt1;

  int passed = 0, total = 0;

  always #5 clk = ~clk;

  hazard_unit #(.NSRC(NSRC), .REGW(REGW), .DEPTH(DEPTH), .FWD_EN(0), .CNTW(16)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_dst(id_dst), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
    .branch_taken(branch_taken), .iready_n(iready_n), .dready_n(dready_n), .dbusy(dbusy),
    .mem_rw(mem_rw), .stall_if(st[0][4]), .stall_id(st[0][3]), .stall_ex(st[0][2]),
    .stall_mem(st[0][1]), .stall_wb(st[0][0]), .nop_if(np[0][4]), .nop_id(np[0][3]),
    .nop_ex(np[0][2]), .nop_mem(np[0][1]), .nop_wb(np[0][0]), .fwd_sel(fs[0]), .stall_cnt(cnt0));

  hazard_unit #(.NSRC(NSRC), .REGW(REGW), .DEPTH(DEPTH), .FWD_EN(1), .CNTW(3)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_dst(id_dst), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
    .branch_taken(branch_taken), .iready_n(iready_n), .dready_n(dready_n), .dbusy(dbusy),
    .mem_rw(mem_rw), .stall_if(st[1][4]), .stall_id(st[1][3]), .stall_ex(st[1][2]),
    .stall_mem(st[1][1]), .stall_wb(st[1][0]), .nop_if(np[1][4]), .nop_id(np[1][3]),
    .nop_ex(np[1][2]), .nop_mem(np[1][1]), .nop_wb(np[1][0]), .fwd_sel(fs[1]), .stall_cnt(cnt1));

  // Model: per configuration, the in-flight writers indexed by age (0 = in EX).
  logic            mv [2][DEPTH];
  logic [REGW-1:0] md [2][DEPTH];
  logic            ml [2][DEPTH];
  int              mcnt [2];
  int              cmax [2] = '{65535, 7};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
  endtask

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      mcnt[c] = 0;
      for (int d = 0; d < DEPTH; d++) begin mv[c][d] = 0; md[c][d] = '0; ml[c][d] = 0; end
    end
  endtask

  function automatic void model_eval(input int c, output logic [4:0] est, output logic [4:0] enp,
                                     output logic [NSRC*SELW-1:0] efs, output logic sh);
    logic ms, haz;
    logic [REGW-1:0] s;
    int yng;
    ms  = iready_n | (dready_n & mem_rw[1]) | (dbusy & mem_rw[0]);
    haz = 0;
    efs = '0;
    for (int k = 0; k < NSRC; k++) begin
      s   = id_src[k*REGW +: REGW];
      yng = -1;
      for (int d = DEPTH - 1; d >= 0; d--)
        if (mv[c][d] && id_src_used[k] && s != 0 && md[c][d] == s) yng = d;
      if (c == 0) begin
        if (yng >= 0 && id_valid) haz = 1;
      end else begin
        if (yng == 0 && ml[c][0] && id_valid) haz = 1;
        efs[k*SELW +: SELW] = 2'(yng + 1);
      end
    end
    est = '0; enp = '0; sh = 0;
    if (ms) begin est = 5'b11111; enp = 5'b10000; end
    else if (branch_taken) enp = 5'b11100;
    else if (haz) begin est = 5'b01000; enp = 5'b10100; sh = 1; end
  endfunction

  task automatic model_update(input int c);
    logic [4:0] est, enp;
    logic [NSRC*SELW-1:0] efs;
    logic sh;
    model_eval(c, est, enp, efs, sh);
    if (est != 5'b11111) begin
      for (int d = DEPTH - 1; d > 0; d--) begin
        mv[c][d] = mv[c][d-1]; md[c][d] = md[c][d-1]; ml[c][d] = ml[c][d-1];
      end
      if (branch_taken || sh) begin mv[c][0] = 0; md[c][0] = '0; ml[c][0] = 0; end
      else begin
        mv[c][0] = id_valid && id_regwrite && id_dst != 0;
        md[c][0] = id_dst; ml[c][0] = id_is_load;
      end
      if (sh && mcnt[c] < cmax[c]) mcnt[c]++;
    end
  endtask

  task automatic check_model();
    logic [4:0] est, enp;
    logic [NSRC*SELW-1:0] efs;
    logic sh;
    for (int c = 0; c < 2; c++) begin
      model_eval(c, est, enp, efs, sh);
      chk($sformatf("m%0d_stall", c), st[c], est);
      chk($sformatf("m%0d_nop", c), np[c], enp);
      chk($sformatf("m%0d_fwd", c), fs[c], efs);
    end
    chk("m0_cnt", cnt0, mcnt[0]);
    chk("m1_cnt", cnt1, mcnt[1]);
  endtask

  // Inputs are stable from posedge+1; check at negedge, advance model at posedge.
  task automatic cycle();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] dst, input logic rw, input logic ld,
                        input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used);
    id_valid = v; id_dst = dst; id_regwrite = rw; id_is_load = ld;
    id_src = {s1, s0}; id_src_used = used;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 2'b00);
    branch_taken = 0; iready_n = 0; dready_n = 0; dbusy = 0; mem_rw = 2'b00;
  endtask

  task automatic do_reset();
    idle();
    #2 rst = 0;
    model_clear();
    #3 rst = 1;
    cycle();
  endtask

  typedef struct {
    logic ir, dr, db;
    logic [1:0] rw;
    logic br;
    logic [4:0] est, enp;
  } vec_t;
  vec_t tbl[8];

  initial begin
    idle();
    model_clear();
    #2;
    chk("reset_cnt0", cnt0, 0);
    chk("reset_cnt1", cnt1, 0);
    chk("reset_stall", {st[0], st[1]}, 0);
    chk("reset_nop", {np[0], np[1]}, 0);
    chk("reset_fwd", {fs[0], fs[1]}, 0);
    #6 rst = 1;
    @(posedge clk); #1;

    // Priority table on an empty scoreboard.
    tbl[0] = '{0, 0, 0, 2'b00, 0, 5'b00000, 5'b00000};
    tbl[1] = '{1, 0, 0, 2'b00, 0, 5'b11111, 5'b10000};
    tbl[2] = '{0, 1, 0, 2'b01, 0, 5'b00000, 5'b00000};
    tbl[3] = '{0, 1, 0, 2'b10, 0, 5'b11111, 5'b10000};
    tbl[4] = '{0, 0, 1, 2'b01, 0, 5'b11111, 5'b10000};
    tbl[5] = '{0, 0, 1, 2'b10, 0, 5'b00000, 5'b00000};
    tbl[6] = '{0, 0, 0, 2'b00, 1, 5'b00000, 5'b11100};
    tbl[7] = '{0, 0, 1, 2'b11, 1, 5'b11111, 5'b10000};
    for (int i = 0; i < 8; i++) begin
      iready_n = tbl[i].ir; dready_n = tbl[i].dr; dbusy = tbl[i].db;
      mem_rw = tbl[i].rw; branch_taken = tbl[i].br;
      #2;
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("tbl%0d_stall%0d", i, c), st[c], tbl[i].est);
        chk($sformatf("tbl%0d_nop%0d", i, c), np[c], tbl[i].enp);
      end
      cycle();
    end

    // FWD_EN=0: addi x5; add x6,x5,x1 stalls three cycles.
    do_reset();
    set_id(1, 5, 1, 0, 0, 0, 2'b00); cycle();
    set_id(1, 6, 1, 0, 5, 1, 2'b11);
    for (int i = 0; i < 3; i++) begin #2 chk("raw_stall_id", st[0][3], 1); cycle(); end
    #2 chk("raw_release", st[0][3], 0);
    chk("raw_cnt", cnt0, 3);
    cycle();

    // FWD_EN=1: lw x7; add x8,x7,x7 -> one stall, then forward from entry 1.
    do_reset();
    set_id(1, 7, 1, 1, 0, 0, 2'b00); cycle();
    set_id(1, 8, 1, 0, 7, 7, 2'b11);
    #2 chk("lu_stall", st[1][3], 1); cycle();
    #2 chk("lu_release", st[1][3], 0);
    chk("lu_fwd", fs[1], {2'd2, 2'd2});
    cycle();

    // FWD_EN=1: addi x3; nop; sub x4,x3,x0 -> no stall, fwd {0,2}.
    do_reset();
    set_id(1, 3, 1, 0, 0, 0, 2'b00); cycle();
    set_id(0, 0, 0, 0, 0, 0, 2'b00); cycle();
    set_id(1, 4, 1, 0, 3, 0, 2'b11);
    #2 chk("fwd_nostall", st[1][3], 0);
    chk("fwd_sel", fs[1], {2'd0, 2'd2});
    cycle();

    // Branch taken coincident with a load-use hazard.
    do_reset();
    set_id(1, 7, 1, 1, 0, 0, 2'b00); cycle();
    set_id(1, 8, 1, 0, 7, 7, 2'b11); branch_taken = 1;
    #2 chk("br_nop", np[1], 5'b11100);
    chk("br_stall_id", st[1][3], 0);
    cycle();
    branch_taken = 0;
    #2 chk("br_cnt", cnt1, 0);
    cycle();

    // Data-memory read stall freezes a pending FWD_EN=0 hazard.
    do_reset();
    set_id(1, 5, 1, 0, 0, 0, 2'b00); cycle();
    set_id(1, 6, 1, 0, 5, 1, 2'b11);
    #2 chk("ms_pre", st[0], 5'b01000); cycle();
    dready_n = 1; mem_rw = 2'b10;
    for (int i = 0; i < 4; i++) begin #2 chk("ms_all", st[0], 5'b11111); cycle(); end
    dready_n = 0; mem_rw = 2'b00;
    for (int i = 0; i < 2; i++) begin #2 chk("ms_resume", st[0][3], 1); cycle(); end
    #2 chk("ms_done", st[0][3], 0);
    chk("ms_cnt", cnt0, 3);
    cycle();

    // Asynchronous reset in the middle of a stall.
    do_reset();
    set_id(1, 5, 1, 0, 0, 0, 2'b00); cycle();
    set_id(1, 6, 1, 0, 5, 1, 2'b11);
    #2 chk("rs_pre", st[0][3], 1); cycle();
    #2 rst = 0;
    #1 chk("rs_stall", {st[0], st[1]}, 0);
    chk("rs_nop", {np[0], np[1]}, 0);
    chk("rs_fwd", {fs[0], fs[1]}, 0);
    chk("rs_cnt0", cnt0, 0);
    chk("rs_cnt1", cnt1, 0);
    model_clear();
    #3 rst = 1;
    #1 chk("rs_after", {st[0][3], st[1][3]}, 0);
    cycle();

    // Counter saturation on the 3-bit FWD_EN=1 instance.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      set_id(1, 7, 1, 1, 0, 0, 2'b00); cycle();
      set_id(1, 8, 1, 0, 7, 7, 2'b11); cycle();
      cycle();
    end
    #2 chk("sat_cnt", cnt1, 7);
    cycle();

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
             $urandom_range(0, 4) < 2, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             2'($urandom_range(0, 3)));
      branch_taken = $urandom_range(0, 9) == 0;
      iready_n     = $urandom_range(0, 15) == 0;
      dready_n     = $urandom_range(0, 7) == 0;
      dbusy        = $urandom_range(0, 7) == 0;
      mem_rw       = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
